// File: rtl/qu_rob_mp.sv
// Parametrised reorder buffer: in-order allocate and commit, NUM_WB_PORTS writeback channels.
// Optional same-cycle writeback-to-commit bypass when QU_ROB_WB_BYPASS_EN is defined.
module qu_rob_mp #(
  parameter int DEPTH        = 8,
  parameter int NUM_WB_PORTS = 2,
  parameter int VALUE_W      = 32,
  parameter int PHYREG_W     = 7,
  localparam int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            alloc_valid_i,
  output logic                            alloc_ready_o,
  input  logic [PHYREG_W-1:0]             alloc_phyreg_old_i,
  input  logic [31:0]                     alloc_dest_i,
  input  logic                            alloc_store_i,
  input  logic                            alloc_load_i,
  output logic [ADDR_W-1:0]               alloc_addr_o,
  input  logic                            exec_valid_i,
  input  logic [ADDR_W-1:0]               exec_addr_i,
  input  logic [NUM_WB_PORTS-1:0]         wb_valid_i,
  input  logic [NUM_WB_PORTS*ADDR_W-1:0]  wb_addr_i,
  input  logic [NUM_WB_PORTS*VALUE_W-1:0] wb_value_i,
  input  logic [NUM_WB_PORTS-1:0]         wb_mispred_i,
  output logic                            commit_valid_o,
  input  logic                            commit_ready_i,
  output logic [ADDR_W-1:0]               commit_addr_o,
  output logic [VALUE_W-1:0]              commit_value_o,
  output logic [31:0]                     commit_dest_o,
  output logic [PHYREG_W-1:0]             commit_phyreg_old_o,
  output logic                            commit_store_o,
  output logic                            commit_load_o,
  output logic                            commit_mispred_o,
  output logic                            flush_o,
  output logic [ADDR_W:0]                 count_o,
  output logic                            empty_o,
  output logic                            full_o
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_RETIRED = 2'b01,
    ST_EXECUTE = 2'b10,
    ST_PENDING = 2'b11
  } ent_state_t;

  ent_state_t           state_q   [DEPTH];
  logic [VALUE_W-1:0]   value_q   [DEPTH];
  logic                 mispred_q [DEPTH];
  logic [31:0]          dest_q    [DEPTH];
  logic [PHYREG_W-1:0]  phyreg_q  [DEPTH];
  logic                 store_q   [DEPTH];
  logic                 load_q    [DEPTH];

  logic [ADDR_W-1:0] head_q, tail_q;
  logic [ADDR_W:0]   count_q;

  logic [DEPTH-1:0]   wb_hit;
  logic [VALUE_W-1:0] wb_val [DEPTH];
  logic [DEPTH-1:0]   wb_mp;

  logic alloc_fire, commit_fire;

  // Per-entry winning writeback; scanning downward lets the lowest channel overwrite last.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      wb_hit[e] = 1'b0;
      wb_val[e] = '0;
      wb_mp[e]  = 1'b0;
      for (int c = NUM_WB_PORTS - 1; c >= 0; c--) begin
        if (wb_valid_i[c] && (wb_addr_i[c*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
          wb_hit[e] = 1'b1;
          wb_val[e] = wb_value_i[c*VALUE_W +: VALUE_W];
          wb_mp[e]  = wb_mispred_i[c];
        end
      end
      if (!(state_q[e] == ST_PENDING || state_q[e] == ST_EXECUTE)) wb_hit[e] = 1'b0;
    end
  end

  // Both sides use valid/ready: a transfer happens in any cycle where valid and ready are
  // both high; valid never depends on ready, and alloc_ready_o depends on registered state only.
  assign alloc_ready_o = !full_o;
  assign alloc_addr_o  = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

`ifdef QU_ROB_WB_BYPASS_EN
  logic bypass;
  assign bypass = wb_hit[head_q];

  always_comb begin
    commit_valid_o   = (state_q[head_q] == ST_RETIRED) || bypass;
    commit_value_o   = bypass ? wb_val[head_q] : value_q[head_q];
    commit_mispred_o = bypass ? wb_mp[head_q]  : mispred_q[head_q];
  end
`else
  always_comb begin
    commit_valid_o   = (state_q[head_q] == ST_RETIRED);
    commit_value_o   = value_q[head_q];
    commit_mispred_o = mispred_q[head_q];
  end
`endif

  assign commit_addr_o       = head_q;
  assign commit_dest_o       = dest_q[head_q];
  assign commit_phyreg_old_o = phyreg_q[head_q];
  assign commit_store_o      = store_q[head_q];
  assign commit_load_o       = load_q[head_q];
  assign commit_fire         = commit_valid_o && commit_ready_i;
  assign flush_o             = commit_fire && commit_mispred_o;

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        state_q[e]   <= ST_EMPTY;
        value_q[e]   <= '0;
        mispred_q[e] <= 1'b0;
        dest_q[e]    <= '0;
        phyreg_q[e]  <= '0;
        store_q[e]   <= 1'b0;
        load_q[e]    <= 1'b0;
      end
    end else if (flush_o) begin
      // Mispredicted branch commits: drop everything younger, restart just past it.
      for (int e = 0; e < DEPTH; e++) state_q[e] <= ST_EMPTY;
      head_q  <= head_q + 1'b1;
      tail_q  <= head_q + 1'b1;
      count_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (commit_fire && (head_q == ADDR_W'(e))) begin
          state_q[e] <= ST_EMPTY;
        end else if (wb_hit[e]) begin
          state_q[e]   <= ST_RETIRED;
          value_q[e]   <= wb_val[e];
          mispred_q[e] <= wb_mp[e];
        end else if (exec_valid_i && (exec_addr_i == ADDR_W'(e)) && (state_q[e] == ST_PENDING)) begin
          state_q[e] <= ST_EXECUTE;
        end else if (alloc_fire && (tail_q == ADDR_W'(e))) begin
          state_q[e]   <= ST_PENDING;
          value_q[e]   <= '0;
          mispred_q[e] <= 1'b0;
          dest_q[e]    <= alloc_dest_i;
          phyreg_q[e]  <= alloc_phyreg_old_i;
          store_q[e]   <= alloc_store_i;
          load_q[e]    <= alloc_load_i;
        end
      end
      if (alloc_fire)  tail_q <= tail_q + 1'b1;
      if (commit_fire) head_q <= head_q + 1'b1;
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_qu_rob_mp.sv
// Bench for qu_rob_mp (DEPTH=8, two writeback channels): directed scenarios then random traffic,
// checked against an in-order commit queue plus a coarse occupancy model.
module tb_qu_rob_mp;
  localparam int DEPTH = 8;
  localparam int NWB   = 2;

  logic        clk, rst_n;
  logic        alloc_valid_i, alloc_ready_o;
  logic [6:0]  alloc_phyreg_old_i;
  logic [31:0] alloc_dest_i;
  logic        alloc_store_i, alloc_load_i;
  logic [2:0]  alloc_addr_o;
  logic        exec_valid_i;
  logic [2:0]  exec_addr_i;
  logic [1:0]  wb_valid_i;
  logic [5:0]  wb_addr_i;
  logic [63:0] wb_value_i;
  logic [1:0]  wb_mispred_i;
  logic        commit_valid_o, commit_ready_i;
  logic [2:0]  commit_addr_o;
  logic [31:0] commit_value_o, commit_dest_o;
  logic [6:0]  commit_phyreg_old_o;
  logic        commit_store_o, commit_load_o, commit_mispred_o;
  logic        flush_o;
  logic [3:0]  count_o;
  logic        empty_o, full_o;

  qu_rob_mp dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_phyreg_old_i(alloc_phyreg_old_i), .alloc_dest_i(alloc_dest_i),
    .alloc_store_i(alloc_store_i), .alloc_load_i(alloc_load_i), .alloc_addr_o(alloc_addr_o),
    .exec_valid_i(exec_valid_i), .exec_addr_i(exec_addr_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_value_i(wb_value_i),
    .wb_mispred_i(wb_mispred_i),
    .commit_valid_o(commit_valid_o), .commit_ready_i(commit_ready_i),
    .commit_addr_o(commit_addr_o), .commit_value_o(commit_value_o),
    .commit_dest_o(commit_dest_o), .commit_phyreg_old_o(commit_phyreg_old_o),
    .commit_store_o(commit_store_o), .commit_load_o(commit_load_o),
    .commit_mispred_o(commit_mispred_o), .flush_o(flush_o),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry status per index: 0 free, 1 allocated awaiting result, 2 result ready.
  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] dest;
    logic [6:0]  phy;
    logic        st;
    logic        ld;
    logic [31:0] val;
    logic        mp;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  logic [REC_W-1:0] exp_q[$];
  int          m_state [DEPTH];
  logic [31:0] m_plan_val [DEPTH];
  logic        m_plan_mp [DEPTH];
  int          m_head, m_tail, m_count;
  logic [31:0] plan_val;
  logic        plan_mp;
  bit          won [DEPTH];
  bit          exp_cv, exp_fire, exp_flush, acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_head = 0; m_tail = 0; m_count = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_state[i] = 0; m_plan_val[i] = '0; m_plan_mp[i] = 1'b0;
      end
      exp_q.delete();
    end else begin
      acc = (m_count < DEPTH);
      chk("alloc_ready", alloc_ready_o, acc);
      chk("alloc_addr", alloc_addr_o, m_tail);
      chk("count", count_o, m_count);
      chk("empty", empty_o, m_count == 0);
      chk("full", full_o, m_count == DEPTH);
      for (int i = 0; i < DEPTH; i++) won[i] = 1'b0;
      for (int c = 0; c < NWB; c++)
        if (wb_valid_i[c] && m_state[wb_addr_i[c*3 +: 3]] == 1) won[wb_addr_i[c*3 +: 3]] = 1'b1;
      exp_cv = (m_state[m_head] == 2);
`ifdef QU_ROB_WB_BYPASS_EN
      exp_cv = exp_cv || won[m_head];
`endif
      chk("commit_valid", commit_valid_o, exp_cv);
      exp_fire  = exp_cv && commit_ready_i;
      exp_flush = exp_fire && m_plan_mp[m_head];
      chk("flush", flush_o, exp_flush);
      if (exp_fire) begin
        m_state[m_head] = 0;
        won[m_head] = 1'b0;
        m_head = (m_head + 1) % DEPTH;
        m_count--;
      end
      if (exp_flush) begin
        for (int i = 0; i < DEPTH; i++) m_state[i] = 0;
        m_tail = m_head;
        m_count = 0;
      end else begin
        for (int i = 0; i < DEPTH; i++) if (won[i]) m_state[i] = 2;
        if (alloc_valid_i && acc) begin
          rec_t r;
          r = '{addr: 3'(m_tail), dest: alloc_dest_i, phy: alloc_phyreg_old_i,
                st: alloc_store_i, ld: alloc_load_i, val: plan_val, mp: plan_mp};
          exp_q.push_back(REC_W'(r));
          m_state[m_tail] = 1;
          m_plan_val[m_tail] = plan_val;
          m_plan_mp[m_tail] = plan_mp;
          m_tail = (m_tail + 1) % DEPTH;
          m_count++;
        end
      end
    end
  end

  // ---------------- commit monitor ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n && commit_valid_o && commit_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("commit_unexpected", 1'b1, 1'b0);
      end else begin
        rec_t r;
        r = rec_t'(exp_q.pop_front());
        chk("commit_addr", commit_addr_o, r.addr);
        chk("commit_value", commit_value_o, r.val);
        chk("commit_dest", commit_dest_o, r.dest);
        chk("commit_phyreg", commit_phyreg_old_o, r.phy);
        chk("commit_store", commit_store_o, r.st);
        chk("commit_load", commit_load_o, r.ld);
        chk("commit_mispred", commit_mispred_o, r.mp);
        if (r.mp) exp_q.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid_i = 1'b0; alloc_phyreg_old_i = '0; alloc_dest_i = '0;
    alloc_store_i = 1'b0; alloc_load_i = 1'b0;
    exec_valid_i = 1'b0; exec_addr_i = '0;
    wb_valid_i = '0; wb_addr_i = '0; wb_value_i = '0; wb_mispred_i = '0;
    commit_ready_i = 1'b0;
    plan_val = '0; plan_mp = 1'b0;
  endtask

  task automatic do_alloc(input logic [31:0] v, input logic mp);
    alloc_valid_i = 1'b1;
    plan_val = v;
    plan_mp = mp;
    alloc_dest_i = $urandom;
    alloc_phyreg_old_i = 7'($urandom_range(0, 127));
    alloc_store_i = 1'($urandom_range(0, 1));
    alloc_load_i = !alloc_store_i && ($urandom_range(0, 1) == 1);
  endtask

  task automatic do_wb(input int c, input int idx, input logic [31:0] v, input logic mp);
    wb_valid_i[c] = 1'b1;
    wb_addr_i[c*3 +: 3] = 3'(idx);
    wb_value_i[c*32 +: 32] = v;
    wb_mispred_i[c] = mp;
  endtask

  // The lowest channel hitting an in-flight entry carries its planned result; all else is decoy.
  task automatic rand_cycle();
    int idx;
    bit carrier;
    idle();
    if ($urandom_range(0, 9) < 7) do_alloc($urandom, $urandom_range(0, 9) == 0);
    commit_ready_i = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < NWB; c++) begin
      if ($urandom_range(0, 9) < 6) begin
        idx = (m_head + $urandom_range(0, DEPTH - 1)) % DEPTH;
        carrier = (m_state[idx] == 1) && !(c == 1 && wb_valid_i[0] && wb_addr_i[2:0] == 3'(idx));
        if (carrier) do_wb(c, idx, m_plan_val[idx], m_plan_mp[idx]);
        else         do_wb(c, idx, $urandom, 1'($urandom_range(0, 1)));
      end
    end
    exec_valid_i = 1'($urandom_range(0, 1));
    exec_addr_i = 3'($urandom_range(0, DEPTH - 1));
    tick();
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200 && m_count > 0; k++) begin
      idle();
      commit_ready_i = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
        if (m_state[(m_head + j) % DEPTH] == 1) begin
          do_wb(0, (m_head + j) % DEPTH, m_plan_val[(m_head + j) % DEPTH],
                m_plan_mp[(m_head + j) % DEPTH]);
          break;
        end
      end
      tick();
    end
    if (m_count != 0) chk("drain_timeout", 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] first_vals [4];
  bit saw_flush;

  initial begin
    first_vals[0] = 32'h00; first_vals[1] = 32'h11;
    first_vals[2] = 32'h22; first_vals[3] = 32'hAA;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", alloc_ready_o, 1'b1);
    chk("rst_commit_valid", commit_valid_o, 1'b0);
    chk("rst_flush", flush_o, 1'b0);
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_full", full_o, 1'b0);
    chk("rst_alloc_addr", alloc_addr_o, 3'd0);
    chk("rst_count", count_o, 4'd0);
    rst_n = 1'b1;

    // Fill all eight entries.
    for (int i = 0; i < DEPTH; i++) begin
      idle();
      do_alloc(i < 4 ? first_vals[i] : $urandom, 1'b0);
      tick();
    end
    idle();
    chk("fill_full", full_o, 1'b1);
    chk("fill_ready", alloc_ready_o, 1'b0);
    chk("fill_count", count_o, 4'd8);
    do_alloc($urandom, 1'b0);
    tick();
    chk("full_reject_count", count_o, 4'd8);

    // Out-of-order writebacks 2,1,0 must commit in order 0,1,2.
    idle(); commit_ready_i = 1'b1; do_wb(0, 2, 32'h22, 1'b0); #1;
    chk("ooo_wait_2", commit_valid_o, 1'b0);
    tick();
    idle(); commit_ready_i = 1'b1; do_wb(0, 1, 32'h11, 1'b0); #1;
    chk("ooo_wait_1", commit_valid_o, 1'b0);
    tick();
    idle(); commit_ready_i = 1'b1; do_wb(0, 0, 32'h00, 1'b0);
    tick();
    idle(); commit_ready_i = 1'b1; #1;
`ifdef QU_ROB_WB_BYPASS_EN
    chk("ooo_head_after_wb0", commit_addr_o, 3'd1);
`else
    chk("ooo_head_after_wb0", commit_addr_o, 3'd0);
`endif
    chk("ooo_commit_ready", commit_valid_o, 1'b1);
    repeat (3) tick();

    // Both channels hit entry 3: channel 0 wins.
    idle(); commit_ready_i = 1'b1;
    do_wb(0, 3, 32'hAA, 1'b0); do_wb(1, 3, 32'hBB, 1'b0); #1;
`ifdef QU_ROB_WB_BYPASS_EN
    chk("collide_value", commit_value_o, 32'hAA);
    tick();
`else
    tick();
    idle(); commit_ready_i = 1'b1; #1;
    chk("collide_value", commit_value_o, 32'hAA);
    tick();
`endif

    // Refill to full, then commit and alloc together while full.
    for (int i = 0; i < 4; i++) begin
      idle(); do_alloc($urandom, 1'b0); tick();
    end
    chk("refill_full", full_o, 1'b1);
    idle(); do_wb(0, 4, m_plan_val[4], 1'b0); tick();
    idle(); commit_ready_i = 1'b1; do_alloc($urandom, 1'b0); #1;
    chk("full_commit_valid", commit_valid_o, 1'b1);
    chk("full_alloc_blocked", alloc_ready_o, 1'b0);
    tick();
    idle(); #1;
    chk("after_full_commit_count", count_o, 4'd7);
    chk("after_full_commit_tail", alloc_addr_o, 3'd4);
    do_alloc($urandom, 1'b0);
    tick();
    chk("after_full_realloc", count_o, 4'd8);
    drain();

    // Reset mid-operation discards contents asynchronously.
    for (int i = 0; i < 3; i++) begin
      idle(); do_alloc($urandom, 1'b0); tick();
    end
    idle();
    rst_n = 1'b0; #1;
    chk("async_rst_count", count_o, 4'd0);
    chk("async_rst_empty", empty_o, 1'b1);
    tick();
    rst_n = 1'b1;

    // Mispredicted branch at entry 1 flushes 2..5 and any alloc in the flush cycle.
    for (int i = 0; i < 6; i++) begin
      idle(); do_alloc($urandom, i == 1); tick();
    end
    saw_flush = 1'b0;
    for (int k = 0; k < 8 && !saw_flush; k++) begin
      idle(); commit_ready_i = 1'b1; do_alloc($urandom, 1'b0);
      if (k == 0) begin
        do_wb(0, 0, m_plan_val[0], 1'b0);
        do_wb(1, 1, m_plan_val[1], 1'b1);
      end
      #1;
      if (flush_o) saw_flush = 1'b1;
      tick();
    end
    chk("flush_seen", saw_flush, 1'b1);
    idle(); #1;
    chk("post_flush_empty", empty_o, 1'b1);
    chk("post_flush_count", count_o, 4'd0);
    chk("post_flush_tail", alloc_addr_o, 3'd2);
    chk("post_flush_commit_valid", commit_valid_o, 1'b0);

    // Writeback straight to a pending head.
    do_alloc(32'h5A, 1'b0); tick();
    idle(); commit_ready_i = 1'b1; do_wb(0, 2, 32'h5A, 1'b0); #1;
`ifdef QU_ROB_WB_BYPASS_EN
    chk("bypass_valid", commit_valid_o, 1'b1);
    chk("bypass_value", commit_value_o, 32'h5A);
    tick();
`else
    chk("nobypass_wait", commit_valid_o, 1'b0);
    tick();
    idle(); commit_ready_i = 1'b1; #1;
    chk("nobypass_valid", commit_valid_o, 1'b1);
    chk("nobypass_value", commit_value_o, 32'h5A);
    tick();
`endif

    // Random traffic, then drain and confirm nothing is left outstanding.
    for (int n = 0; n < 3000; n++) rand_cycle();
    drain();
    idle(); #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_empty", empty_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
